// File: rtl/ntt_core_param.sv
// ntt_core_param: mode-selectable NTT engine mod Q (forward CT, inverse GS
// with N^-1 scaling), streaming load/store, external registered zeta ROM.
module ntt_core_param #(
  parameter int N    = 256,
  parameter int LOGN = 8,
  parameter int W    = 23,
  parameter int Q    = 8380417,
  parameter int NINV = 8347681
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            mode,
  output logic            busy,
  output logic            done,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic            out_last,
  output logic [LOGN-1:0] zeta_addr,
  input  logic [W-1:0]    zeta_data
);

  localparam int W2 = 2 * W;
  localparam logic [W-1:0]    QV   = W'(Q);
  localparam logic [W-1:0]    NI   = W'(NINV);
  localparam logic [W2-1:0]   QP   = W2'(Q);
  localparam logic [LOGN-1:0] ONE  = LOGN'(1);
  localparam logic [LOGN-1:0] IMAX = LOGN'(N - 1);
  localparam logic [LOGN-1:0] HALF = LOGN'(N / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCHZ,
    S_ZWAIT,
    S_BFLY,
    S_SCALE,
    S_STORE,
    S_DONE
  } state_t;

  state_t          state_q;
  logic            mode_q;
  logic [LOGN-1:0] idx_q;
  logic [LOGN-1:0] len_q;
  logic [LOGN-1:0] base_q;
  logic [LOGN-1:0] off_q;
  logic [LOGN-1:0] k_q;
  logic [W-1:0]    z_q;
  logic [W-1:0]    a_q [N];

  function automatic logic [W-1:0] addq(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, QV}) s = s - {1'b0, QV};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] subq(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    logic [W:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (x < y) d = d + {1'b0, QV};
    return d[W-1:0];
  endfunction

  function automatic logic [W-1:0] mulq(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    logic [W2-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    p = p % QP;
    return p[W-1:0];
  endfunction

  logic            st_ld;
  logic            st_bf;
  logic            st_sc;
  logic            ld_beat;
  logic [LOGN-1:0] jl;
  logic [LOGN-1:0] jh;
  logic [LOGN-1:0] rl;
  logic [LOGN-1:0] idx_nx;
  logic [LOGN-1:0] k_nx;
  logic [LOGN:0]   base_nx;
  logic            grp_end;
  logic            stg_end;
  logic            all_end;
  logic [W-1:0]    lo;
  logic [W-1:0]    hi;
  logic [W-1:0]    dif;
  logic [W-1:0]    ma;
  logic [W-1:0]    mb;
  logic [W-1:0]    prod;

  assign st_ld   = state_q == S_LOAD;
  assign st_bf   = state_q == S_BFLY;
  assign st_sc   = state_q == S_SCALE;
  assign ld_beat = st_ld && in_valid;

  assign jl      = base_q + off_q;
  assign jh      = jl + len_q;
  assign rl      = st_bf ? jl : idx_q;
  assign idx_nx  = idx_q + ONE;
  assign k_nx    = mode_q ? (k_q - ONE) : (k_q + ONE);

  // base_nx overflows into bit LOGN exactly when the stage's last group ends
  assign base_nx = {1'b0, base_q} + {len_q, 1'b0};
  assign grp_end = off_q == (len_q - ONE);
  assign stg_end = base_nx[LOGN];
  assign all_end = stg_end &&
                   (mode_q ? (len_q == HALF) : (len_q == ONE));

  assign lo   = a_q[rl];
  assign hi   = a_q[jh];
  assign dif  = subq(lo, hi);
  assign ma   = st_sc ? lo : z_q;
  assign mb   = st_sc ? NI : (mode_q ? dif : hi);
  assign prod = mulq(ma, mb);

  logic            we_l;
  logic            we_h;
  logic [LOGN-1:0] wa_l;
  logic [W-1:0]    wd_l;
  logic [W-1:0]    wd_h;

  always_comb begin
    we_l = 1'b0;
    we_h = 1'b0;
    wa_l = idx_q;
    wd_l = in_data;
    wd_h = '0;
    unique case (1'b1)
      ld_beat: we_l = 1'b1;
      st_bf: begin
        we_l = 1'b1;
        we_h = 1'b1;
        wa_l = jl;
        if (mode_q) begin
          wd_l = addq(lo, hi);
          wd_h = prod;
        end else begin
          wd_l = addq(lo, prod);
          wd_h = subq(lo, prod);
        end
      end
      st_sc: begin
        we_l = 1'b1;
        wd_l = prod;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we_l) a_q[wa_l] <= wd_l;
    if (we_h) a_q[jh] <= wd_h;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      idx_q     <= '0;
      len_q     <= '0;
      base_q    <= '0;
      off_q     <= '0;
      k_q       <= '0;
      z_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      zeta_addr <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q   <= mode;
            idx_q    <= '0;
            len_q    <= '0;
            base_q   <= '0;
            off_q    <= '0;
            k_q      <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            idx_q <= idx_nx;
            if (idx_q == IMAX) begin
              in_ready  <= 1'b0;
              len_q     <= mode_q ? ONE : HALF;
              k_q       <= mode_q ? IMAX : ONE;
              zeta_addr <= mode_q ? IMAX : ONE;
              state_q   <= S_FETCHZ;
            end
          end
        end
        S_FETCHZ: state_q <= S_ZWAIT;
        S_ZWAIT: begin
          z_q     <= mode_q ? subq('0, zeta_data) : zeta_data;
          state_q <= S_BFLY;
        end
        S_BFLY: begin
          off_q <= off_q + ONE;
          if (grp_end) begin
            off_q  <= '0;
            base_q <= base_nx[LOGN-1:0];
            if (all_end) begin
              idx_q <= '0;
              if (mode_q) begin
                state_q <= S_SCALE;
              end else begin
                out_valid <= 1'b1;
                out_data  <= a_q[0];
                out_last  <= 1'b0;
                state_q   <= S_STORE;
              end
            end else begin
              k_q       <= k_nx;
              zeta_addr <= k_nx;
              state_q   <= S_FETCHZ;
              if (stg_end) begin
                len_q <= mode_q ? (len_q << 1) : (len_q >> 1);
              end
            end
          end
        end
        S_SCALE: begin
          idx_q <= idx_nx;
          if (idx_q == IMAX) begin
            out_valid <= 1'b1;
            out_data  <= a_q[0];
            out_last  <= 1'b0;
            state_q   <= S_STORE;
          end
        end
        S_STORE: begin
          if (out_ready) begin
            idx_q <= idx_nx;
            if (idx_q == IMAX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              out_data <= a_q[idx_nx];
              out_last <= idx_nx == IMAX;
            end
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_core_param.sv
// tb_ntt_core_param: directed + random checks of ntt_core_param against
// a plain-arithmetic NTT reference model and a computed zeta ROM.
module tb_ntt_core_param;

  localparam int N    = 256;
  localparam int LOGN = 8;
  localparam int W    = 23;
  localparam int QI   = 8380417;
  localparam int NINV = 8347681;
  localparam longint QL = QI;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            mode;
  logic            busy;
  logic            done;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            out_last;
  logic [LOGN-1:0] zeta_addr;
  logic [W-1:0]    zeta_data;

  ntt_core_param #(
    .N(N), .LOGN(LOGN), .W(W), .Q(QI), .NINV(NINV)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .mode(mode),
    .busy(busy),
    .done(done),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .zeta_addr(zeta_addr),
    .zeta_data(zeta_data)
  );

  int tests;
  int fails;
  int cyc = 0;
  int dcyc;
  int nout;
  longint zt [N];
  longint vin [N];
  longint vout [N];
  longint vexp [N];
  longint vorig [N];
  longint vsave [N];
  logic [LOGN-1:0] zq [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // registered zeta ROM
  always @(posedge clk) zeta_data <= W'(zt[zeta_addr]);

  function automatic longint zeta_of(input int k);
    int r;
    longint p;
    r = 0;
    p = 1;
    for (int b = 0; b < LOGN; b++)
      r = r | (((k >> b) & 1) << (LOGN - 1 - b));
    for (int e = 0; e < r; e++) p = (p * 1753) % QL;
    return p;
  endfunction

  function automatic longint mm(input longint a, input longint b);
    return (a * b) % QL;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit m);
    longint a [N];
    longint z, t, u;
    int k;
    for (int i = 0; i < N; i++) a[i] = vin[i];
    if (!m) begin
      k = 0;
      for (int len = N / 2; len >= 1; len = len / 2)
        for (int s0 = 0; s0 < N; s0 += 2 * len) begin
          k++;
          z = zt[k];
          for (int j = s0; j < s0 + len; j++) begin
            t = mm(z, a[j + len]);
            a[j + len] = (a[j] - t + QL) % QL;
            a[j] = (a[j] + t) % QL;
          end
        end
    end else begin
      k = N;
      for (int len = 1; len < N; len = len * 2)
        for (int s0 = 0; s0 < N; s0 += 2 * len) begin
          k--;
          z = (QL - zt[k]) % QL;
          for (int j = s0; j < s0 + len; j++) begin
            u = a[j];
            a[j] = (u + a[j + len]) % QL;
            a[j + len] = mm(z, (u - a[j + len] + QL) % QL);
          end
        end
      for (int i = 0; i < N; i++) a[i] = mm(a[i], NINV);
    end
    for (int i = 0; i < N; i++) vexp[i] = a[i];
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_zeta_addr"}, zeta_addr, 0);
  endtask

  // one operation; pulse_at/abort_at are cycle offsets from start (0 = off)
  task automatic op(input bit m, input bit bp,
                    input int pulse_at, input int abort_at);
    int s, rel, ii, tick;
    bit fin, stall;
    logic [W-1:0] pd;
    logic pl;
    logic [LOGN-1:0] lz;
    ii = 0; nout = 0; dcyc = -1; fin = 0; stall = 0; tick = 0;
    pd = '0; pl = 1'b0;
    zq.delete();
    @(negedge clk);
    lz = zeta_addr;
    start = 1'b1; mode = m; in_valid = 1'b0; out_ready = 1'b0;
    s = cyc;
    while (!fin) begin
      @(negedge clk);
      rel = cyc - s;
      start = 1'b0;
      mode = m;
      if (pulse_at > 0 && rel == pulse_at) begin
        start = 1'b1;
        mode = ~m;
      end
      if (zeta_addr != lz) begin
        zq.push_back(zeta_addr);
        lz = zeta_addr;
      end
      if (abort_at > 0 && rel == abort_at) begin
        chk("busy_pre_abort", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset("abort");
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        fin = 1;
      end else begin
        if (stall) begin
          chk("hold_data", out_data, pd);
          chk("hold_last", out_last, pl);
        end
        in_valid = (ii < N) && (bp ? ($urandom_range(0, 1) == 1) : 1'b1);
        in_data = in_valid ? W'(vin[ii]) : W'($urandom);
        if (in_valid && in_ready) ii++;
        out_ready = bp ? (tick % 3 == 0) : 1'b1;
        tick++;
        if (out_valid) begin
          chk("out_range", out_data < W'(QL), 1);
          if (out_ready) begin
            if (nout < N) vout[nout] = out_data;
            chk("out_last", out_last, nout == N - 1);
            nout++;
          end
        end
        stall = out_valid && !out_ready;
        pd = out_data;
        pl = out_last;
        if (done) begin
          dcyc = rel;
          fin = 1;
        end
        if (rel > 20000) begin
          chk("timeout", rel, 0);
          fin = 1;
        end
      end
    end
    if (dcyc >= 0) begin
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("busy_idle", busy, 0);
      in_valid = 1'b0;
    end
  endtask

  task automatic cmp(input string tag, input int cyc_exp);
    if (cyc_exp > 0) chk({tag, "_done_cyc"}, dcyc, cyc_exp);
    chk({tag, "_beats"}, nout, N);
    for (int i = 0; i < N; i++) chk(tag, vout[i], vexp[i]);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    mode = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    for (int k = 0; k < N; k++) zt[k] = zeta_of(k);
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    // forward delta
    for (int i = 0; i < N; i++) vin[i] = (i == 0) ? 1 : 0;
    model(0);
    op(0, 0, 0, 0);
    cmp("fwd_delta", 2047);

    // forward zero, with zeta address order
    for (int i = 0; i < N; i++) vin[i] = 0;
    model(0);
    op(0, 0, 0, 0);
    cmp("fwd_zero", 2047);
    chk("zeta_cnt", zq.size(), N - 1);
    for (int i = 0; i < zq.size() && i < N - 1; i++)
      chk("zeta_seq", zq[i], i + 1);

    // random forward with an ignored start pulse during BFLY
    for (int i = 0; i < N; i++) begin
      vorig[i] = $urandom_range(0, 32'(QL - 1));
      vin[i] = vorig[i];
    end
    model(0);
    op(0, 0, N + 50, 0);
    cmp("fwd_rand", 2047);
    for (int i = 0; i < N; i++) vsave[i] = vout[i];

    // inverse round trip
    for (int i = 0; i < N; i++) begin
      vin[i] = vsave[i];
      vexp[i] = vorig[i];
    end
    op(1, 0, 0, 0);
    cmp("round_trip", 2303);

    // backpressure on both streams
    for (int i = 0; i < N; i++) begin
      vin[i] = vorig[i];
      vexp[i] = vsave[i];
    end
    op(0, 1, 0, 0);
    cmp("backpressure", 0);

    // abort during stage-3 BFLY, then clean rerun
    op(0, 0, 0, N + 280);
    for (int i = 0; i < N; i++) vin[i] = (i == 0) ? 1 : 0;
    model(0);
    op(0, 0, 0, 0);
    cmp("rerun_delta", 2047);

    // boundary: all Q-1 forward then inverse
    for (int i = 0; i < N; i++) vin[i] = QL - 1;
    model(0);
    op(0, 0, 0, 0);
    cmp("fwd_qm1", 2047);
    for (int i = 0; i < N; i++) begin
      vin[i] = vout[i];
      vexp[i] = QL - 1;
    end
    op(1, 0, 0, 0);
    cmp("inv_qm1", 2303);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ntt_core_param.md
# ntt_core_param

Parametrised, mode-selectable NTT engine for the Dilithium datapath. It is the successor to the fixed 256-point forward-only NTT sequencer. It performs either the forward Cooley-Tukey NTT or the inverse Gentleman-Sande NTT, with final N⁻¹ scaling, on an N-coefficient polynomial mod Q. Coefficients stream in and out over valid/ready handshakes; twiddles come from an external registered zeta ROM.

## Interface
- `N`, 256: number of coefficients; power of two, ≥4.
- `LOGN`, 8: log2(N).
- `W`, 23: coefficient width; Q < 2^W.
- `Q`, 8380417: modulus.
- `NINV`, 8347681: N⁻¹ mod Q.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin operation; sampled only in IDLE.
- `mode`  in  1  0 = forward NTT, 1 = inverse NTT; latched with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on completion.
- `in_valid` / `in_ready` / `in_data[W-1:0]`  in/out/in  coefficient input stream; index 0 first.
- `out_valid` / `out_ready` / `out_data[W-1:0]` / `out_last`  out/in/out/out  coefficient output stream; index 0 first.
- `zeta_addr[LOGN-1:0]`  out  zeta ROM address.
- `zeta_data[W-1:0]`  in  zeta ROM data; registered, valid one cycle after the address is presented.

## Operation
- States: IDLE, LOAD, FETCHZ, ZWAIT, BFLY, SCALE, STORE, DONE.
- **IDLE**: `start`=1 latches `mode`, clears the counters and moves to LOAD.
- **LOAD**: `in_ready`=1. Each `in_valid && in_ready` beat writes `a[idx]` and increments `idx`. After beat N-1 → FETCHZ. Inputs must be < Q; no reduction is applied on load.
- **Forward schedule**: `k`=0. `len` = N/2 down to 1. For each `start` = 0, 2len, …: `k`++, z = zeta[k]. For each j in [start, start+len): t = z·a[j+len] mod Q; a[j+len] = (a[j]−t) mod Q; a[j] = (a[j]+t) mod Q.
- **Inverse schedule**: `k`=N. `len` = 1 up to N/2. For each group: `k`−−, z = (Q−zeta[k]) mod Q. For each j: u = a[j]; a[j] = (u+a[j+len]) mod Q; a[j+len] = z·((u−a[j+len]) mod Q) mod Q.
- **FETCHZ**: drives `zeta_addr`=k. **ZWAIT**: registers z. Then → BFLY.
- **BFLY**: one butterfly per cycle, `len` cycles per group. At the end of a group → FETCHZ for the next group. At the end of the last stage → SCALE if mode=1, else STORE.
- **SCALE**: a[i] = a[i]·NINV mod Q, one coefficient per cycle, N cycles.
- **Arithmetic**: products are 2W bits, reduced fully to [0,Q). Add uses a conditional subtract of Q. Subtract uses a conditional add of Q. Every stored value stays in [0,Q).
- **STORE**: `out_valid`=1 with `out_data`=a[idx]. Advance only on `out_valid && out_ready`. `out_last`=1 on index N-1. After the last beat → DONE.
- **DONE**: `done`=1 for one cycle → IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `zeta_addr`=0. State = IDLE; all counters 0.
- `rst_n` asserted mid-operation aborts immediately to IDLE. The next `start` runs cleanly.
- `start` while busy is ignored, and `mode` is not re-latched.
- Compute cycles: 2·(N−1) for FETCHZ/ZWAIT plus LOGN·N/2 for BFLY. For N=256 that is 510 + 1024 = 1534. Inverse adds N cycles for SCALE.
- With `in_valid` and `out_ready` held high: `start` sampled at edge 0, LOAD beats on edges 1..N, `done` high in cycle 2N+1534+1. For N=256, forward = 2047 and inverse = 2303.
- Under backpressure, `out_data` and `out_last` hold stable while `out_valid && !out_ready`. `in_valid`=0 stalls LOAD without losing data.
- `in_ready` is 0 outside LOAD, and `out_valid` is 0 outside STORE.
- `done` and `start` may coincide only when `done` is in DONE. `start` is not accepted until the following IDLE cycle.

## Test plan
- **Forward delta**: in = {1,0,…,0}, mode=0 → all 256 outputs = 1, `out_last` on beat 255, `done` at cycle 2047.
- **Forward zero**: all-zero input, mode=0 → all outputs 0. Zeta address sequence = 1..255 in order.
- **Round trip**: random vector (< Q) forward, then feed the result with mode=1 → original vector bit-exact. Inverse `done` at cycle 2303.
- **Backpressure**: `out_ready` toggles 1,0,0,1… and `in_valid` pseudo-random → same output data as the unstalled run. `out_data` holds on stalled cycles.
- **Reset and ignored start**: `start` pulsed in BFLY → no effect. `rst_n` low during BFLY of stage 3 → `busy`=0 and all outputs at reset values immediately. A rerun of the forward delta passes.
- **Boundary values**: all coefficients = Q−1, forward then inverse → all Q−1 returned. No output ever ≥ Q (assertion on every beat).
